router_port_rx: RTL and testbench

//  Receive side of one router input port: decodes the serial frame_n/valid_n/din packet stream

---
 rtl/router_port_rx.sv | 196 +++++++++++++++++++
 tb/tb_router_port_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/router_port_rx.sv
// router_port_rx: receive side of one router input port.
//   Deserialises the frame_n/valid_n/din pin protocol into a destination
//   address and a byte stream. Completed bytes land in a show-ahead FIFO
//   whose head is registered onto m_*.
// Ports:
//   clk, reset      clock / async active-high reset
//   frame_n,valid_n,din  serial packet input (address then data, LSB first)
//   busy_n          start-of-packet throttle to the sender
//   addr,addr_valid captured destination + one-cycle update pulse
//   m_data,m_sop,m_eop,m_err,m_valid,m_ready  FIFO head stream
//   ovf             one-cycle pulse when a byte is dropped on a full FIFO
module router_port_rx #(
  parameter int ADDR_W     = 4,
  parameter int PAD_CYCLES = 5,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              din,
  output logic              busy_n,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [7:0]        m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              m_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(PAD_CYCLES + ADDR_W + 8);

  typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] ash_q, ash_d, addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic [7:0]        byte_q, byte_d, nb;
  logic              sop_q, sop_d;
  logic              push_q, push_d;
  logic [10:0]       pword_q, pword_d;   // {err, eop, sop, data}

  // FIFO storage; the head entry stays in memory and is mirrored in head_q
  logic [10:0]       mem [DEPTH];
  logic [PW:0]       wptr_q, wptr_d, rptr_q, rptr_d, fifo_cnt_d;
  logic [10:0]       head_q, head_d;
  logic              m_valid_q, m_valid_d;
  logic              busy_n_q, busy_n_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, wr;

  assign full = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign pop  = m_valid_q & m_ready;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is legal then
  assign wr   = push_q & (~full | pop);

  always_comb begin
    ovf_d      = push_q & full & ~pop;
    wptr_d     = wptr_q + (PW+1)'(wr);
    rptr_d     = rptr_q + (PW+1)'(pop);
    fifo_cnt_d = wptr_d - rptr_d;
    busy_n_d   = fifo_cnt_d <= (PW+1)'(DEPTH - AF_THRESH);
    // Head uses the pre-push write pointer: a new entry shows one cycle after its write
    m_valid_d  = (wptr_q != rptr_d);
    head_d     = mem[rptr_d[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q[PW-1:0]] <= pword_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      head_q    <= '0;
      m_valid_q <= 1'b0;
      busy_n_q  <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      head_q    <= head_d;
      m_valid_q <= m_valid_d;
      busy_n_q  <= busy_n_d;
      ovf_q     <= ovf_d;
    end
  end

  // Packet decoder
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ash_d        = ash_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    byte_d       = byte_q;
    sop_d        = sop_q;
    push_d       = 1'b0;
    pword_d      = pword_q;
    nb           = byte_q;
    if (!valid_n) nb[cnt_q[2:0]] = din;
    case (state_q)
      IDLE: if (!frame_n) begin
        ash_d   = {din, ash_q[ADDR_W-1:1]};
        cnt_d   = CW'(1);
        state_d = ADDR;
      end
      ADDR: begin
        if (frame_n) state_d = IDLE;
        else begin
          ash_d = {din, ash_q[ADDR_W-1:1]};
          if (cnt_q == CW'(ADDR_W-1)) begin
            addr_d       = ash_d;
            addr_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = PAD;
          end else cnt_d = cnt_q + CW'(1);
        end
      end
      PAD: begin
        if (frame_n) state_d = IDLE;
        else if (cnt_q == CW'(PAD_CYCLES-1)) begin
          cnt_d   = '0;
          byte_d  = '0;
          sop_d   = 1'b1;
          state_d = DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      DATA: begin
        if (ovf_d) begin
          // Previous byte of this packet was dropped: discard the rest of it
          state_d = frame_n ? IDLE : DROP;
        end else if (!valid_n && cnt_q == CW'(7)) begin
          push_d  = 1'b1;
          pword_d = {1'b0, frame_n, sop_q, nb};
          sop_d   = 1'b0;
          cnt_d   = '0;
          byte_d  = '0;
          if (frame_n) state_d = IDLE;
        end else if (frame_n) begin
          // Truncation: flush the partial byte (upper bits already zero)
          if (!valid_n || cnt_q != '0) begin
            push_d  = 1'b1;
            pword_d = {1'b1, 1'b1, sop_q, nb};
          end
          state_d = IDLE;
        end else if (!valid_n) begin
          byte_d = nb;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DROP: if (frame_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ash_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      byte_q       <= '0;
      sop_q        <= 1'b0;
      push_q       <= 1'b0;
      pword_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ash_q        <= ash_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      byte_q       <= byte_d;
      sop_q        <= sop_d;
      push_q       <= push_d;
      pword_q      <= pword_d;
    end
  end

  assign busy_n     = busy_n_q;
  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign m_data     = head_q[7:0];
  assign m_sop      = head_q[8];
  assign m_eop      = head_q[9];
  assign m_err      = head_q[10];
  assign m_valid    = m_valid_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_router_port_rx.sv
// Scoreboard bench for router_port_rx: the driver derives expected bytes and
// addresses from the packet it sends; a negedge monitor pops and compares.
module tb_router_port_rx;
  localparam int DEPTH = 16;
  localparam int AF    = 4;

  logic clk = 0, reset = 1;
  logic frame_n = 1, valid_n = 1, din = 0, m_ready = 0;
  logic busy_n, addr_valid, m_sop, m_eop, m_err, m_valid, ovf;
  logic [3:0] addr;
  logic [7:0] m_data;

  router_port_rx dut (
    .clk(clk), .reset(reset), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .busy_n(busy_n), .addr(addr), .addr_valid(addr_valid), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop), .m_err(m_err), .m_valid(m_valid),
    .m_ready(m_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [10:0] exp_q[$];   // {err, eop, sop, data}
  logic [3:0]  addr_q[$];
  int n_cmp = 0, n_bad = 0, ovf_cnt = 0, exp_ovf = 0;
  int rdy_mode = 0;        // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 0;
      1: m_ready = 1;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor
  always @(negedge clk) if (!reset) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL byte_unexpected: got %0h expected none", {m_err, m_eop, m_sop, m_data});
      end else chk("byte", {21'd0, m_err, m_eop, m_sop, m_data}, {21'd0, exp_q.pop_front()});
    end
    if (addr_valid) begin
      if (addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL addr_valid_unexpected: got addr %0h expected no pulse", addr);
      end else chk("addr", {28'd0, addr}, {28'd0, addr_q.pop_front()});
    end
    if (ovf) ovf_cnt++;
  end

  // Sends one packet; bits[i] is data bit i. abort_pad>=0 raises frame_n in that
  // pad cycle; cut>=0 stops driving after that many data bits with frame_n still low.
  task automatic send_pkt(input logic [3:0] a, input logic [255:0] bits, input int nbits,
                          input int abort_pad, input int cut, input bit gaps);
    bit drop = 0;
    logic [7:0] cur = 0;
    for (int i = 0; i < 4; i++) begin
      frame_n = 0; valid_n = 1; din = a[i]; tick();
    end
    addr_q.push_back(a);
    for (int p = 0; p < 5; p++) begin
      if (p == abort_pad) begin frame_n = 1; valid_n = 1; tick(); return; end
      valid_n = 1'($urandom_range(0, 1)); din = 1'($urandom_range(0, 1)); tick();
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == cut) begin valid_n = 1; return; end
      if (gaps) repeat ($urandom_range(0, 2)) begin
        frame_n = 0; valid_n = 1; din = 1'($urandom_range(0, 1)); tick();
      end
      frame_n = (i == nbits - 1); valid_n = 0; din = bits[i];
      cur[i % 8] = bits[i];
      if (i % 8 == 7 || i == nbits - 1) begin
        if (!drop) begin
          if (exp_q.size() >= DEPTH) begin drop = 1; exp_ovf++; end
          else exp_q.push_back({(i % 8 != 7), (i == nbits - 1), (i < 8), cur});
        end
        cur = 0;
      end
      tick();
    end
    frame_n = 1; valid_n = 1;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    rdy_mode = 1;
    while ((exp_q.size() != 0 || m_valid) && t < 400) begin tick(); t++; end
    if (t >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d entries left expected 0", nm, exp_q.size());
    end
    repeat (3) tick();
  endtask

  initial begin
    logic [255:0] bits;
    int npk;
    repeat (3) tick();
    chk("rst_busy_n", busy_n, 1);
    chk("rst_addr", addr, 0);
    chk("rst_addr_valid", addr_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_ovf", ovf, 0);
    reset = 0; tick();

    // 1: two full bytes
    rdy_mode = 1;
    bits = '0; bits[15:0] = 16'h3CA5;
    send_pkt(4'h5, bits, 16, -1, -1, 0);
    drain("t1");
    chk("t1_addr_hold", addr, 5);

    // 2: one byte plus 4-bit truncated tail, back-to-back with a second packet
    bits = '0; bits[11:0] = 12'hFFF;
    send_pkt(4'h9, bits, 12, -1, -1, 0);
    bits = '0; bits[7:0] = 8'h81;
    send_pkt(4'h2, bits, 8, -1, -1, 0);
    drain("t2");

    // 3: fill with 4-byte packets until busy_n drops
    rdy_mode = 0; tick();
    npk = 0;
    while (busy_n && npk < 8) begin
      for (int k = 0; k < 8; k++) bits[k*32 +: 32] = $urandom();
      send_pkt(4'($urandom_range(0, 15)), bits, 32, -1, -1, 0);
      npk++;
      repeat (3) tick();
      chk("t3_busy_n", busy_n, ((DEPTH - exp_q.size()) >= AF));
    end
    chk("t3_packets", npk, 4);
    drain("t3");
    chk("t3_busy_release", busy_n, 1);

    // 4: 20-byte packet into a stalled FIFO
    rdy_mode = 0; tick();
    for (int k = 0; k < 8; k++) bits[k*32 +: 32] = $urandom();
    send_pkt(4'hC, bits, 160, -1, -1, 0);
    repeat (3) tick();
    chk("t4_ovf_count", ovf_cnt, exp_ovf);
    chk("t4_exp_ovf", exp_ovf, 1);
    chk("t4_busy_n", busy_n, 0);
    drain("t4");
    bits = '0; bits[15:0] = 16'h6E17;
    send_pkt(4'h3, bits, 16, -1, -1, 0);
    drain("t4b");

    // 5: abort in pad cycle 3, then a normal packet
    send_pkt(4'hA, bits, 16, 3, -1, 0);
    repeat (4) tick();
    chk("t5_no_push", m_valid, 0);
    bits = '0; bits[7:0] = 8'hD2;
    send_pkt(4'h6, bits, 8, -1, -1, 0);
    drain("t5");

    // 6: async reset mid-DATA with 3 bytes queued
    rdy_mode = 0; tick();
    for (int k = 0; k < 8; k++) bits[k*32 +: 32] = $urandom();
    send_pkt(4'h7, bits, 40, -1, 28, 0);
    repeat (3) tick();
    chk("t6_queued", m_valid, 1);
    #2 reset = 1;
    #1;
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_busy_n", busy_n, 1);
    exp_q.delete(); addr_q.delete();
    frame_n = 1; valid_n = 1;
    tick(); tick();
    reset = 0; tick();
    bits = '0; bits[23:0] = 24'h5A0FC3;
    send_pkt(4'hE, bits, 24, -1, -1, 0);
    drain("t6");

    // Random packets, random gaps and back-pressure
    rdy_mode = 2;
    for (int p = 0; p < 14; p++) begin
      for (int k = 0; k < 8; k++) bits[k*32 +: 32] = $urandom();
      send_pkt(4'($urandom_range(0, 15)), bits, $urandom_range(1, 40), -1, -1, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain("rand");

    chk("end_ovf_count", ovf_cnt, exp_ovf);
    chk("end_bytes_left", exp_q.size(), 0);
    chk("end_addr_left", addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end
endmodule
